// File: rtl/segway_pkg.sv
// Shared widths, default gain and signed clipping helper for the Segway datapath.
package segway_pkg;

    localparam int unsigned PTCH_W   = 16;
    localparam int unsigned ERR_W    = 10;
    localparam int unsigned INT_W    = 18;
    localparam int unsigned PID_W    = 12;
    localparam int unsigned SUM_W    = 15;
    localparam int unsigned SS_CNT_W = 27;
    localparam int unsigned SS_W     = 8;

    localparam logic [4:0] P_COEFF_DEF = 5'h0C;

    // Clip a signed 16-bit value into the signed range of 'width' bits.
    // The result is returned sign-extended to 16 bits; callers truncate.
    function automatic logic signed [15:0] sat_signed(
        input logic signed [15:0] value,
        input int unsigned        width
    );
        logic signed [15:0] hi;
        logic signed [15:0] lo;
        hi = 16'sh7FFF >>> (16 - width);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/segway_pid_soft_start_tmr.sv
// Soft-start ramp: 27-bit counter whose top byte scales torque in after power-up.
module soft_start_tmr
    import segway_pkg::*;
#(
    parameter logic FAST_SIM = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pwr_up,
    output logic [SS_W-1:0] ss_tmr
);

    localparam logic [SS_CNT_W-1:0] STEP = FAST_SIM ? SS_CNT_W'(256) : SS_CNT_W'(1);

    logic [SS_CNT_W-1:0] cnt_q;
    logic [SS_CNT_W-1:0] cnt_d;

    // Clear while powered down, climb while powered, stop once the top byte is full.
    always_comb begin
        cnt_d = cnt_q;
        if (!pwr_up) begin
            cnt_d = '0;
        end else if (cnt_q[SS_CNT_W-1 -: SS_W] != '1) begin
            cnt_d = cnt_q + STEP;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ss_tmr = cnt_q[SS_CNT_W-1 -: SS_W];

endmodule

// File: rtl/segway_pid.sv
// Segway balance controller: saturated PID on pitch / pitch rate plus soft-start ramp.
module segway_pid
    import segway_pkg::*;
#(
    parameter logic [4:0] P_COEFF  = P_COEFF_DEF,
    parameter logic       FAST_SIM = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld,
    input  logic signed [PTCH_W-1:0] ptch,
    input  logic signed [PTCH_W-1:0] ptch_rt,
    input  logic                     pwr_up,
    input  logic                     rider_off,
    output logic signed [PID_W-1:0]  PID_cntrl,
    output logic [SS_W-1:0]          ss_tmr
);

    logic signed [ERR_W-1:0]  err_sat;
    logic signed [INT_W-1:0]  err_ext;
    logic signed [INT_W-1:0]  int_sum;
    logic signed [INT_W-1:0]  integ_q;
    logic signed [INT_W-1:0]  integ_d;
    logic signed [PTCH_W-1:0] rt_shift;
    logic signed [SUM_W-1:0]  p_term;
    logic signed [SUM_W-1:0]  i_term;
    logic signed [SUM_W-1:0]  d_term;
    logic signed [SUM_W-1:0]  pid_sum;
    logic signed [PID_W-1:0]  pid_q;
    logic signed [PID_W-1:0]  pid_d;

    // Error saturation and the three PID terms.
    always_comb begin
        err_sat  = ERR_W'(sat_signed(ptch, ERR_W));
        p_term   = SUM_W'(err_sat) * SUM_W'($signed({1'b0, P_COEFF}));
        i_term   = SUM_W'($signed(integ_q[INT_W-1:6]));
        rt_shift = ptch_rt >>> 6;
        d_term   = -SUM_W'(rt_shift);
        pid_sum  = p_term + i_term + d_term;
        pid_d    = PID_W'(sat_signed(16'(pid_sum), PID_W));
    end

    // Integrator next state: rider_off clears, vld accumulates unless the add would overflow.
    always_comb begin
        err_ext = INT_W'(err_sat);
        int_sum = integ_q + err_ext;
        integ_d = integ_q;
        if (rider_off) begin
            integ_d = '0;
        end else if (vld) begin
            if ((integ_q[INT_W-1] == err_ext[INT_W-1]) &&
                (int_sum[INT_W-1] != integ_q[INT_W-1])) begin
                integ_d = integ_q;
            end else begin
                integ_d = int_sum;
            end
        end
    end

    // Integrator and output command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ_q <= '0;
            pid_q   <= '0;
        end else begin
            integ_q <= integ_d;
            pid_q   <= pid_d;
        end
    end

    assign PID_cntrl = pid_q;

    soft_start_tmr #(
        .FAST_SIM(FAST_SIM)
    ) u_soft_start (
        .clk   (clk),
        .rst   (rst),
        .pwr_up(pwr_up),
        .ss_tmr(ss_tmr)
    );

endmodule
